// File: rtl/lfsr_pkg.sv
// Shared definitions for the Fibonacci LFSR: default parameters, the legal
// width range, and the maximal-length tap table.
// Optional feature macro: LFSR_LOCKUP_RECOVERY_EN (see rtl/lfsr.sv).
package lfsr_pkg;

  // Default MSB index of the state (width 8) and default seed.
  localparam int          LFSR_DW      = 7;
  localparam logic [31:0] LFSR_DEFAULT = 32'h0000_0001;

  // Legal register widths.
  localparam int LFSR_MIN_W = 3;
  localparam int LFSR_MAX_W = 32;

  // Maximal-length feedback taps for an n-bit register.
  // In the returned mask, bit k selects state[k].
  // Polynomial term x^(k+1) maps to bit k.
  // A width outside 3..32 yields zero, and the top level rejects that width.
  function automatic logic [31:0] lfsr_taps(input int n);
    logic [31:0] mask;
    mask = 32'h0;
    case (n)
      3:  mask = 32'h0000_0006;
      4:  mask = 32'h0000_000C;
      5:  mask = 32'h0000_0014;
      6:  mask = 32'h0000_0030;
      7:  mask = 32'h0000_0060;
      8:  mask = 32'h0000_00B8;
      9:  mask = 32'h0000_0110;
      10: mask = 32'h0000_0240;
      11: mask = 32'h0000_0500;
      12: mask = 32'h0000_0829;
      13: mask = 32'h0000_100D;
      14: mask = 32'h0000_2015;
      15: mask = 32'h0000_6000;
      16: mask = 32'h0000_D008;
      17: mask = 32'h0001_2000;
      18: mask = 32'h0002_0400;
      19: mask = 32'h0004_0023;
      20: mask = 32'h0009_0000;
      21: mask = 32'h0014_0000;
      22: mask = 32'h0030_0000;
      23: mask = 32'h0042_0000;
      24: mask = 32'h00E1_0000;
      25: mask = 32'h0120_0000;
      26: mask = 32'h0200_0023;
      27: mask = 32'h0400_0013;
      28: mask = 32'h0900_0000;
      29: mask = 32'h1400_0000;
      30: mask = 32'h2000_0029;
      31: mask = 32'h4800_0000;
      32: mask = 32'h8020_0003;
      default: mask = 32'h0;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/lfsr_if.sv
// State/feedback bundle between the LFSR register and its feedback network.
// There is no handshake: state is valid every cycle, and fb follows it
// combinationally. The register side is the master, and the feedback side
// is the slave.
interface lfsr_if #(
  parameter int N = 8
);
  logic [N-1:0] state;
  logic         fb;

  modport master (output state, input fb);
  modport slave  (input state, output fb);
endinterface

// File: rtl/lfsr_feedback.sv
// Feedback network: parity of the state bits selected by the maximal-length
// tap mask for this width.
module lfsr_feedback
  import lfsr_pkg::*;
#(
  parameter int N = 8
) (
  lfsr_if.slave bus
);

  localparam logic [31:0] TAPS = lfsr_taps(N);
  localparam logic [N-1:0] MASK = TAPS[N-1:0];

  // XOR-reduce the tapped bits to form the new LSB.
  always_comb begin
    bus.fb = ^(bus.state & MASK);
  end

endmodule

// File: rtl/lfsr.sv
// Fibonacci XOR LFSR top level. The state shifts left by one every clock.
// The new LSB is the parity of the tapped bits. A low RST_N at a clock edge
// reloads the seed.
// Optional macro LFSR_LOCKUP_RECOVERY_EN adds an all-zero state detector.
// When that detector sees the all-zero state, it reloads the seed at the
// next edge. Without the macro, the all-zero state persists.
module lfsr #(
  parameter int          LFSR_DW      = lfsr_pkg::LFSR_DW,
  parameter logic [31:0] LFSR_DEFAULT = lfsr_pkg::LFSR_DEFAULT
) (
  input  logic             CLK,
  input  logic             RST_N,
  output logic [LFSR_DW:0] O_DATA
);

  localparam int N = LFSR_DW + 1;

  // Reject unsupported widths and a seed that truncates to zero.
  // A zero seed would lock the register at zero.
  if (N < lfsr_pkg::LFSR_MIN_W || N > lfsr_pkg::LFSR_MAX_W) begin : g_bad_width
    $error("lfsr: LFSR_DW=%0d outside supported range 2..31", LFSR_DW);
  end

  localparam logic [N-1:0] SEED = LFSR_DEFAULT[N-1:0];

  if (SEED == '0) begin : g_bad_seed
    $error("lfsr: LFSR_DEFAULT truncated to %0d bits is zero", N);
  end

  logic [N-1:0] state_q;
  logic [N-1:0] state_d;

  lfsr_if #(.N(N)) fb_if ();

  assign fb_if.state = state_q;

  lfsr_feedback #(.N(N)) u_feedback (
    .bus (fb_if.slave)
  );

  // Next state: shift in the feedback bit. With the optional detector,
  // the all-zero state is replaced by the seed.
  always_comb begin
    state_d = {state_q[N-2:0], fb_if.fb};
`ifdef LFSR_LOCKUP_RECOVERY_EN
    if (state_q == '0) begin
      state_d = SEED;
    end
`endif
  end

  // State register. Reset is synchronous and overrides the shift.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign O_DATA = state_q;

endmodule

// File: tb/tb_lfsr.sv
// Bench for the 8-bit LFSR with seed 0x01 and a 100 MHz clock. It covers:
// - reset behaviour;
// - the first states after release;
// - the full 255-step period;
// - a mid-sequence reset pulse;
// - all-zero state handling, with and without LFSR_LOCKUP_RECOVERY_EN.
module tb_lfsr;

  localparam int           W    = 8;
  localparam logic [W-1:0] SEED = 8'h01;

  // ---------------------------------------------------------------- clock/reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  lfsr_if #(.N(W)) mon_if ();

  // The monitor only observes state; the feedback lane is tied off.
  assign mon_if.fb = 1'b0;

  lfsr #(
    .LFSR_DW      (7),
    .LFSR_DEFAULT (32'h1)
  ) dut (
    .CLK    (clk),
    .RST_N  (rst_n),
    .O_DATA (mon_if.state)
  );

  // ---------------------------------------------------------------- scoreboard
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] model;

  // Reference next state for x^8+x^6+x^5+x^4+1, written out bit by bit.
  function automatic logic [W-1:0] model_next(input logic [W-1:0] s);
    logic fb;
    fb = s[7] ^ s[5] ^ s[4] ^ s[3];
`ifdef LFSR_LOCKUP_RECOVERY_EN
    if (s == 8'h00) return SEED;
`endif
    return {s[6:0], fb};
  endfunction

  // ---------------------------------------------------------------- driver tasks
  // Drive RST_N at the falling edge and push the expected state. Then wait
  // past the rising edge, so outputs are sampled 1 time unit after it.
  task automatic drive_cycle(input logic rst_v);
    @(negedge clk);
    rst_n = rst_v;
    model = rst_v ? model_next(model) : SEED;
    exp_q.push_back(model);
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string name);
    logic [W-1:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty, got %02h", name, mon_if.state);
    end else begin
      e = exp_q.pop_front();
      if (mon_if.state !== e) begin
        errors++;
        $display("FAIL %s: got %02h expected %02h", name, mon_if.state, e);
      end
    end
  endtask

  task automatic check_val(input string name, input logic [W-1:0] e);
    checks++;
    if (mon_if.state !== e) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", name, mon_if.state, e);
    end
  endtask

  // ---------------------------------------------------------------- vectors
  typedef struct {
    logic         rst_n;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs[10];

  initial begin
    bit seen[256];
    int distinct;
    int zeros;
    int dups;

    // Reset held for 4 cycles, then the first six shifts after release.
    vecs[0] = '{1'b0, 8'h01};
    vecs[1] = '{1'b0, 8'h01};
    vecs[2] = '{1'b0, 8'h01};
    vecs[3] = '{1'b0, 8'h01};
    vecs[4] = '{1'b1, 8'h02};
    vecs[5] = '{1'b1, 8'h04};
    vecs[6] = '{1'b1, 8'h08};
    vecs[7] = '{1'b1, 8'h11};
    vecs[8] = '{1'b1, 8'h23};
    vecs[9] = '{1'b1, 8'h47};

    model = SEED;

    for (int i = 0; i < 10; i++) begin
      drive_cycle(vecs[i].rst_n);
      check_val($sformatf("vec%0d", i), vecs[i].exp);
      check_out($sformatf("sb_vec%0d", i));
    end

    // Full period: reset once, then 255 free-running steps.
    drive_cycle(1'b0);
    check_out("period_reset");
    foreach (seen[k]) seen[k] = 1'b0;
    distinct = 0;
    zeros    = 0;
    dups     = 0;
    for (int i = 1; i <= 255; i++) begin
      drive_cycle(1'b1);
      check_out("period_step");
      if (mon_if.state == 8'h00) zeros++;
      if (seen[mon_if.state]) dups++;
      else begin
        seen[mon_if.state] = 1'b1;
        distinct++;
      end
    end
    check_val("period_wrap", 8'h01);
    checks++;
    if (distinct != 255 || zeros != 0 || dups != 0) begin
      errors++;
      $display("FAIL period_unique: distinct %0d zeros %0d dups %0d, required 255/0/0",
               distinct, zeros, dups);
    end

    // Mid-sequence single-cycle reset pulse.
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b1);
      check_out("pre_pulse");
    end
    check_val("pre_pulse_state", 8'h08);
    drive_cycle(1'b0);
    check_val("pulse_seed", 8'h01);
    check_out("sb_pulse_seed");
    drive_cycle(1'b1);
    check_val("pulse_restart0", 8'h02);
    check_out("sb_pulse_restart0");
    drive_cycle(1'b1);
    check_val("pulse_restart1", 8'h04);
    check_out("sb_pulse_restart1");

    // All-zero state: forced between edges, then released before the next edge.
    force dut.state_q = '0;
    #1;
    release dut.state_q;
    model = 8'h00;
    check_val("forced_zero", 8'h00);
    drive_cycle(1'b1);
`ifdef LFSR_LOCKUP_RECOVERY_EN
    check_val("lockup_recover", 8'h01);
`else
    check_val("lockup_persist", 8'h00);
`endif
    check_out("sb_lockup0");
    drive_cycle(1'b1);
    check_out("sb_lockup1");

    // Reset takes the register out of any state.
    drive_cycle(1'b0);
    check_val("final_reset", 8'h01);
    check_out("sb_final_reset");

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d entries left, required 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lfsr.md
LFSR -- requirements
Module: lfsr

Interface
REQ-001 Parameter LFSR_DW, default 7: MSB index of the state; register width N = LFSR_DW+1.
REQ-002 Parameter LFSR_DEFAULT, default 1: seed value, truncated to N bits.
REQ-003 CLK  input  1  sole clock; all state updates occur on the rising edge.
REQ-004 RST_N  input  1  reset; synchronous, active-low.
REQ-005 O_DATA  output  N ([LFSR_DW:0])  current LFSR state.
REQ-006 The block SHALL have no other ports.

Function
REQ-007 The block SHALL implement a Fibonacci XOR LFSR with an N-bit state register.
REQ-008 Each rising CLK edge with RST_N high SHALL perform one left shift: state <= {state[N-2:0], fb}.
REQ-009 fb SHALL be the XOR of the state bits selected by the maximal-length tap mask for width N.
REQ-010 For N=8 the mask SHALL select bits 7, 5, 4 and 3, giving polynomial x^8+x^6+x^5+x^4+1.
REQ-011 Every supported N SHALL use a maximal-length polynomial, so the period from any nonzero seed is 2^N-1.
REQ-012 O_DATA SHALL be driven directly from the state register, with no combinational path from inputs.
REQ-013 Latency: O_DATA SHALL show the next state one cycle after each enabled edge; no enable input exists and the LFSR advances every cycle.
REQ-014 Supported range: 2 <= LFSR_DW <= 31 (N = 3..32); elaboration SHALL fail outside this range.
REQ-015 Elaboration SHALL fail if the truncated seed is zero.
REQ-016 The state SHALL never reach all-zero from a legal seed, and the sequence SHALL wrap after 2^N-1 steps back to the seed.

Reset
REQ-017 On a rising CLK edge with RST_N low, the state SHALL load LFSR_DEFAULT[N-1:0].
REQ-018 O_DATA SHALL equal the seed for the cycle following any reset edge.
REQ-019 Reset asserted mid-sequence SHALL override the shift at that edge; there is no asynchronous path.
REQ-020 The first shift SHALL occur at the first rising edge that samples RST_N high.

Configuration
REQ-021 Macro LFSR_LOCKUP_RECOVERY_EN, when defined, SHALL add an all-zero state detector.
REQ-022 With the macro defined, an all-zero state SHALL be replaced by the seed at the next edge, with reset taking priority.
REQ-023 Without the macro, there is no detector: the all-zero state SHALL persist, and the logic SHALL be identical to REQ-007..REQ-020.

Structure
REQ-024 Package lfsr_pkg SHALL hold:
- the tap-mask function/table lfsr_taps(N), returning a 32-bit mask for N = 3..32;
- defaults LFSR_DW and LFSR_DEFAULT;
- the range constants LFSR_MIN_W = 3 and LFSR_MAX_W = 32.
REQ-025 Sub-module lfsr_feedback SHALL compute fb as the combinational parity of (state & mask).
REQ-026 lfsr SHALL instantiate lfsr_feedback once and contain only the state register and the optional recovery logic.

Verification
All scenarios use N=8, seed 0x01 and a 100 MHz clock unless stated otherwise.
REQ-027 Reset: RST_N low for 4 cycles -> O_DATA = 0x01 throughout.
REQ-028 Release: RST_N high -> O_DATA sequence 0x02, 0x04, 0x08, 0x11, 0x23, 0x47 on successive edges.
REQ-029 Free-run of 255 cycles after release -> O_DATA returns to 0x01, and no value repeats or equals 0x00 within the period.
REQ-030 RST_N pulsed low for one cycle mid-sequence -> O_DATA = 0x01 on the next cycle, then the sequence restarts from 0x02.
REQ-031 LFSR_DW=15 with seed 0xACE1 -> 65535-cycle period with no zero state; LFSR_DW=1 or seed 0 -> elaboration error.
REQ-032 With LFSR_LOCKUP_RECOVERY_EN defined, force the state to 0x00 -> O_DATA = 0x01 on the next edge; without the macro, the state stays 0x00.
